decode_queue: RTL and testbench

//  Buffered, parametrised decode stage between fetch and execute. Queues DEPTH fetched
//  {pc, instr} pairs, decodes the head (RV32I + Zicsr + system), registers control bundle.

---
 rtl/decode_pkg.sv | 107 ++++++++++
 rtl/instr_decoder.sv | 137 +++++++++++++
 rtl/decode_queue.sv | 162 ++++++++++++++++
 tb/tb_decode_queue.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared definitions for the decode stage: control bundle
//               layout and field offsets, ALU / EX-mux / WB-mux / memory-length
//               codes, RV32I opcode values and the trap-hold FSM state type.
//               The muldiv/md_op fields are only driven when the design is
//               built with DECODE_M_EXT_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Control bundle, MSB first. Write enables are active low so that an
    // all-inactive bundle (CTRL_NOP) has them high.
    typedef struct packed {
        logic       rf_we_n;    // [25]    register-file write enable (low)
        logic       mem_we_n;   // [24]    data-memory write enable (low)
        logic       csr_we_n;   // [23]    CSR write enable (low)
        logic [3:0] alu_func1;  // [22:19] ALU operation, {bit30, funct3}
        logic [2:0] alu_func2;  // [18:16] branch compare / CSR op (funct3)
        logic [1:0] ex_sel1;    // [15:14] operand 1: DATA1 / PC
        logic [1:0] ex_sel2;    // [13:12] operand 2: DATA2 / IMM / CSR
        logic [1:0] wb_sel;     // [11:10] writeback source
        logic       mem_re;     // [9]     data-memory read
        logic [1:0] mem_len;    // [8:7]   access size
        logic       mem_uns;    // [6]     zero-extend load
        logic       branch;     // [5]
        logic       jump;       // [4]
        logic       muldiv;     // [3]
        logic [2:0] md_op;      // [2:0]   M-extension funct3
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    localparam int CTRL_RF_WE_N_OFS  = 25;
    localparam int CTRL_MEM_WE_N_OFS = 24;
    localparam int CTRL_CSR_WE_N_OFS = 23;
    localparam int CTRL_ALU_F1_OFS   = 19;
    localparam int CTRL_ALU_F2_OFS   = 16;
    localparam int CTRL_EX_SEL1_OFS  = 14;
    localparam int CTRL_EX_SEL2_OFS  = 12;
    localparam int CTRL_WB_SEL_OFS   = 10;
    localparam int CTRL_MEM_RE_OFS   = 9;
    localparam int CTRL_MEM_LEN_OFS  = 7;
    localparam int CTRL_MEM_UNS_OFS  = 6;
    localparam int CTRL_BRANCH_OFS   = 5;
    localparam int CTRL_JUMP_OFS     = 4;
    localparam int CTRL_MULDIV_OFS   = 3;
    localparam int CTRL_MD_OP_OFS    = 0;

    localparam ctrl_t CTRL_NOP = '{rf_we_n: 1'b1, mem_we_n: 1'b1, csr_we_n: 1'b1,
                                   default: '0};

    // ALU func1 codes ({instr[30], funct3})
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    // ALU func2 codes: branch compare conditions (CSR ops reuse funct3)
    localparam logic [2:0] ALU_F2_EQ  = 3'b000;
    localparam logic [2:0] ALU_F2_NE  = 3'b001;
    localparam logic [2:0] ALU_F2_LT  = 3'b100;
    localparam logic [2:0] ALU_F2_GE  = 3'b101;
    localparam logic [2:0] ALU_F2_LTU = 3'b110;
    localparam logic [2:0] ALU_F2_GEU = 3'b111;

    // EX operand mux selects
    localparam logic [1:0] EX_DATA   = 2'd0;    // DATA1 / DATA2
    localparam logic [1:0] EX_IMM_PC = 2'd1;    // PC (op1) / IMM (op2)
    localparam logic [1:0] EX_CSR    = 2'd2;

    // WB mux codes
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;

    // Memory access length codes
    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    // Opcodes
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [0:0] {
        ST_RUN       = 1'b0,
        ST_TRAP_HOLD = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Purely combinational RV32I + Zicsr + system decoder.
//               Macro DECODE_M_EXT_EN: when defined, OP funct7=0000001
//               (M extension) is legal and sets muldiv/md_op.
// Ports       : i_instr   - raw instruction
//               o_ctrl    - control bundle (CTRL_NOP when illegal)
//               o_illegal - encoding not recognised
//               o_ecall / o_ebreak / o_mret - exact-match system instructions
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
    import decode_pkg::*;
(
    input  logic [31:0]       i_instr,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_illegal,
    output logic              o_ecall,
    output logic              o_ebreak,
    output logic              o_mret
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_legal;
    ctrl_t      w_ctrl;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    always_comb begin
        w_ctrl  = CTRL_NOP;
        w_legal = 1'b1;
        case (w_opcode)
            OPC_LUI: begin
                w_ctrl.rf_we_n = 1'b0;
                w_ctrl.wb_sel  = WB_IMM;
            end
            OPC_AUIPC: begin
                w_ctrl.rf_we_n = 1'b0;
                w_ctrl.ex_sel1 = EX_IMM_PC;
                w_ctrl.ex_sel2 = EX_IMM_PC;
            end
            OPC_JAL: begin
                w_ctrl.rf_we_n = 1'b0;
                w_ctrl.jump    = 1'b1;
                w_ctrl.ex_sel1 = EX_IMM_PC;
                w_ctrl.ex_sel2 = EX_IMM_PC;
            end
            OPC_JALR: begin
                w_legal        = (w_funct3 == 3'b000);
                w_ctrl.rf_we_n = 1'b0;
                w_ctrl.jump    = 1'b1;
                w_ctrl.ex_sel2 = EX_IMM_PC;
            end
            OPC_BRANCH: begin
                w_legal          = (w_funct3[2:1] != 2'b01);
                w_ctrl.branch    = 1'b1;
                w_ctrl.alu_func1 = ALU_SUB;
                w_ctrl.alu_func2 = w_funct3;
            end
            OPC_LOAD: begin
                w_legal        = (w_funct3 != 3'd3) && (w_funct3 != 3'd6) && (w_funct3 != 3'd7);
                w_ctrl.rf_we_n = 1'b0;
                w_ctrl.mem_re  = 1'b1;
                w_ctrl.wb_sel  = WB_MEM;
                w_ctrl.ex_sel2 = EX_IMM_PC;
                w_ctrl.mem_len = w_funct3[1:0];
                w_ctrl.mem_uns = w_funct3[2];
            end
            OPC_STORE: begin
                w_legal         = (w_funct3 <= 3'd2);
                w_ctrl.mem_we_n = 1'b0;
                w_ctrl.ex_sel2  = EX_IMM_PC;
                w_ctrl.mem_len  = w_funct3[1:0];
            end
            OPC_OP_IMM: begin
                if (w_funct3 == 3'b001) begin
                    w_legal = (w_funct7 == 7'b0000000);
                end else if (w_funct3 == 3'b101) begin
                    // only bit30 (arithmetic shift) may be set
                    w_legal = ((w_funct7 & 7'b1011111) == 7'b0000000);
                end
                w_ctrl.rf_we_n   = 1'b0;
                w_ctrl.ex_sel2   = EX_IMM_PC;
                // immediate bit30 only selects SRA for shifts; for other
                // OP-IMM instructions it is just immediate data
                w_ctrl.alu_func1 = {(w_funct3 == 3'b101) & i_instr[30], w_funct3};
            end
            OPC_OP: begin
                w_ctrl.rf_we_n   = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    w_legal = 1'b1;
                end else if (w_funct7 == 7'b0100000) begin
                    w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
                end else if (w_funct7 == 7'b0000001) begin
`ifdef DECODE_M_EXT_EN
                    w_legal       = 1'b1;
                    w_ctrl.muldiv = 1'b1;
                    w_ctrl.md_op  = w_funct3;
`else
                    w_legal = 1'b0;
`endif
                end else begin
                    w_legal = 1'b0;
                end
                w_ctrl.rf_we_n   = 1'b0;
                w_ctrl.alu_func1 = {i_instr[30], w_funct3};
            end
            OPC_SYSTEM: begin
                w_legal = (w_funct3 != 3'b100);
                // funct3=000 (ecall/ebreak/mret/...) writes nothing
                if (w_funct3 != 3'b000) begin
                    w_ctrl.csr_we_n  = 1'b0;
                    w_ctrl.rf_we_n   = 1'b0;
                    w_ctrl.ex_sel2   = EX_CSR;
                    w_ctrl.alu_func2 = w_funct3;
                end
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_ctrl = CTRL_NOP;
        end
    end

    assign o_ctrl    = w_ctrl;
    assign o_illegal = ~w_legal;
    assign o_ecall   = (i_instr == 32'h0000_0073);
    assign o_ebreak  = (i_instr == 32'h0010_0073);
    assign o_mret    = (i_instr == 32'h3020_0073);

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue
// Description : Buffered decode stage. A DEPTH-entry FIFO of {pc, instr}
//               feeds instr_decoder; the decoded head is captured in an
//               output register with valid/ready handshakes on both sides.
//               flush_i discards everything. With HALT_ON_TRAP=1, loading an
//               illegal/ecall/ebreak instruction stops further loads until
//               flush_i. Macro DECODE_M_EXT_EN enables M-extension decode.
// Ports       : clk_i, reset_i (async, active high)
//               fetch side  : valid_i, ready_o, instr_i, pc_i
//               flush_i
//               execute side: valid_o, ready_i, pc_o, instr_o, ctrl_o,
//                             illegal_o, ecall_o, ebreak_o, mret_o
// Revision    : 1.0 - initial release
// ============================================================================
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int PC_W         = 32,
    parameter bit HALT_ON_TRAP = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [31:0]       instr_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [31:0]       instr_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              illegal_o,
    output logic              ecall_o,
    output logic              ebreak_o,
    output logic              mret_o
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   c_full  = (AW+1)'(DEPTH);

    logic [PC_W-1:0]   r_pc_mem    [DEPTH];
    logic [31:0]       r_instr_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_instr;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_illegal;
    logic              r_ecall;
    logic              r_ebreak;
    logic              r_mret;

    logic              w_push;
    logic              w_load;
    logic              w_trap;
    logic [CTRL_W-1:0] w_dec_ctrl;
    logic              w_dec_illegal;
    logic              w_dec_ecall;
    logic              w_dec_ebreak;
    logic              w_dec_mret;

    // Full means full: a pop in the same cycle does not free a slot early.
    assign ready_o = (r_count < c_full) & ~flush_i;
    assign w_push  = valid_i & ready_o;
    assign w_load  = (~r_valid | ready_i) & (r_count != '0) &
                     (r_state == ST_RUN) & ~flush_i;
    assign w_trap  = w_dec_illegal | w_dec_ecall | w_dec_ebreak;

    instr_decoder u_dec (
        .i_instr   (r_instr_mem[r_rd_ptr]),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal),
        .o_ecall   (w_dec_ecall),
        .o_ebreak  (w_dec_ebreak),
        .o_mret    (w_dec_mret)
    );

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= pc_i;
            r_instr_mem[r_wr_ptr] <= instr_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_load};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= ST_RUN;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:       if (HALT_ON_TRAP && w_load && w_trap) w_state_nxt = ST_TRAP_HOLD;
            ST_TRAP_HOLD: w_state_nxt = ST_TRAP_HOLD;
            default:      w_state_nxt = ST_RUN;
        endcase
        if (flush_i) w_state_nxt = ST_RUN;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= '0;
            r_ctrl    <= CTRL_NOP;
            r_illegal <= 1'b0;
            r_ecall   <= 1'b0;
            r_ebreak  <= 1'b0;
            r_mret    <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_pc      <= r_pc_mem[r_rd_ptr];
            r_instr   <= r_instr_mem[r_rd_ptr];
            r_ctrl    <= w_dec_ctrl;
            r_illegal <= w_dec_illegal;
            r_ecall   <= w_dec_ecall;
            r_ebreak  <= w_dec_ebreak;
            r_mret    <= w_dec_mret;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o   = r_valid;
    assign pc_o      = r_pc;
    assign instr_o   = r_instr;
    assign ctrl_o    = r_ctrl;
    assign illegal_o = r_illegal;
    assign ecall_o   = r_ecall;
    assign ebreak_o  = r_ebreak;
    assign mret_o    = r_mret;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_queue
// Description : Self-checking bench for decode_queue. Accepted pushes queue an
//               expected issue record; a monitor compares the DUT output
//               register against it every cycle and retires it on handshake.
//               Honours DECODE_M_EXT_EN for the expected M-extension decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_queue;
    import decode_pkg::*;

    localparam int DEPTH        = 4;
    localparam int PC_W         = 32;
    localparam bit HALT_ON_TRAP = 1'b1;
`ifdef DECODE_M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        ctrl_t           ctrl;
        logic            ill;
        logic            ec;
        logic            eb;
        logic            mr;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [31:0]       instr_i = '0;
    logic [PC_W-1:0]   pc_i = '0;
    logic              flush_i = 1'b0;
    logic              valid_o;
    logic              ready_i = 1'b0;
    logic [PC_W-1:0]   pc_o;
    logic [31:0]       instr_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic              illegal_o;
    logic              ecall_o;
    logic              ebreak_o;
    logic              mret_o;

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .HALT_ON_TRAP(HALT_ON_TRAP)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .pc_o(pc_o), .instr_o(instr_o), .ctrl_o(ctrl_o),
        .illegal_o(illegal_o), .ecall_o(ecall_o), .ebreak_o(ebreak_o), .mret_o(mret_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        exp_q[$];          // output register entry (if any) + queued entries
    logic [31:0] mq[$];             // words waiting in the DUT FIFO
    bit          m_out   = 1'b0;    // model: output register full
    bit          m_halt  = 1'b0;    // model: halted after a trap
    bit          m_ready = 1'b1;    // model: expected ready_o this cycle

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode, written straight from the instruction-set rules.
    function automatic exp_t model(input logic [31:0] w, input logic [PC_W-1:0] pc);
        exp_t e; ctrl_t c; logic [2:0] f3; logic [6:0] f7; bit ok;
        f3 = w[14:12]; f7 = w[31:25]; c = CTRL_NOP; ok = 1'b1;
        case (w[6:0])
            7'b0110111: begin c.rf_we_n = 0; c.wb_sel = WB_IMM; end
            7'b0010111: begin c.rf_we_n = 0; c.ex_sel1 = EX_IMM_PC; c.ex_sel2 = EX_IMM_PC; end
            7'b1101111, 7'b1100111: begin
                ok = w[3] || (f3 == 3'd0);
                c.rf_we_n = 0; c.jump = 1; c.ex_sel2 = EX_IMM_PC;
                c.ex_sel1 = w[3] ? EX_IMM_PC : EX_DATA;
            end
            7'b1100011: begin
                ok = !(f3 inside {3'd2, 3'd3});
                c.branch = 1; c.alu_func1 = ALU_SUB; c.alu_func2 = f3;
            end
            7'b0000011: begin
                ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                c.rf_we_n = 0; c.mem_re = 1; c.wb_sel = WB_MEM; c.ex_sel2 = EX_IMM_PC;
                c.mem_len = f3[1:0]; c.mem_uns = (f3 >= 3'd4);
            end
            7'b0100011: begin
                ok = (f3 < 3'd3);
                c.mem_we_n = 0; c.ex_sel2 = EX_IMM_PC; c.mem_len = f3[1:0];
            end
            7'b0010011: begin
                if (f3 == 3'd1)      ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                c.rf_we_n = 0; c.ex_sel2 = EX_IMM_PC;
                c.alu_func1 = {(f3 == 3'd5) && (f7 == 7'h20), f3};
            end
            7'b0110011: begin
                ok = (f7 == 7'h00) || ((f7 == 7'h20) && (f3 inside {3'd0, 3'd5})) ||
                     (M_EN && (f7 == 7'h01));
                c.rf_we_n = 0; c.alu_func1 = {f7 == 7'h20, f3};
                if (f7 == 7'h01) begin c.muldiv = 1; c.md_op = f3; end
            end
            7'b1110011: begin
                ok = (f3 != 3'd4);
                if (f3 != 3'd0) begin
                    c.csr_we_n = 0; c.rf_we_n = 0; c.ex_sel2 = EX_CSR; c.alu_func2 = f3;
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) c = CTRL_NOP;
        e.pc = pc; e.instr = w; e.ctrl = c; e.ill = !ok;
        e.ec = (w == 32'h0000_0073); e.eb = (w == 32'h0010_0073); e.mr = (w == 32'h3020_0073);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 12))
            0: ;
            1: case ($urandom_range(0, 3))
                   0: r = 32'h0000_0073;
                   1: r = 32'h0010_0073;
                   2: r = 32'h3020_0073;
                   default: r = 32'h0000_200F;
               endcase
            2:  r[6:0] = 7'b1100011;
            3:  r[6:0] = 7'b0110111;
            4:  r[6:0] = 7'b0010111;
            5:  r[6:0] = 7'b1101111;
            6:  r[6:0] = 7'b1100111;
            7:  r[6:0] = 7'b0000011;
            8:  r[6:0] = 7'b0100011;
            9, 10: r[6:0] = 7'b0010011;
            11: r[6:0] = 7'b0110011;
            default: r[6:0] = 7'b1110011;
        endcase
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        return r;
    endfunction

    // Drive one cycle of inputs (called just after a rising edge), record the
    // expected issue for an accepted push, then advance the model past the edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                        input logic rdy, input logic fl);
        bit acc; bit ld; exp_t e; logic [31:0] w;
        valid_i = v; instr_i = ins; pc_i = pc; ready_i = rdy; flush_i = fl;
        m_ready = (mq.size() < DEPTH) && !fl;
        acc = v && m_ready;
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(model(ins, pc));
        @(posedge clk_i); #1;
        if (fl) begin
            mq.delete(); m_out = 0; m_halt = 0;
        end else begin
            ld = (!m_out || rdy) && (mq.size() > 0) && !m_halt;
            if (ld) begin
                w = mq.pop_front();
                e = model(w, '0);
                m_out = 1;
                if (HALT_ON_TRAP && (e.ill || e.ec || e.eb)) m_halt = 1;
            end else if (rdy) begin
                m_out = 0;
            end
            if (acc) mq.push_back(ins);
        end
    endtask

    // Monitor: checks handshake signals and the presented instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!reset_i && !flush_i) begin
                chk("valid_o", {63'd0, valid_o}, {63'd0, m_out});
                chk("ready_o", {63'd0, ready_o}, {63'd0, m_ready});
                if (valid_o) begin
                    chk("issue_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q[0];
                        chk("issue_pc_instr", {pc_o, instr_o}, {e.pc, e.instr});
                        chk("issue_ctrl", 64'(ctrl_o), 64'(e.ctrl));
                        chk("issue_flags", {60'd0, illegal_o, ecall_o, ebreak_o, mret_o},
                            {60'd0, e.ill, e.ec, e.eb, e.mr});
                        if (ready_i) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        ctrl_t cv;
        logic [PC_W-1:0] pc;
        bit fl;
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_ctrl", 64'(ctrl_o), 64'(CTRL_NOP));
        chk("rst_pc_instr", {pc_o, instr_o}, 64'd0);
        chk("rst_flags", {60'd0, illegal_o, ecall_o, ebreak_o, mret_o}, 64'd0);
        reset_i = 1'b0;

        // ---------------- ADDI x1,x0,5 ----------------
        step(1, 32'h0050_0093, 32'h100, 1, 0);
        chk("addi_latency", {63'd0, valid_o}, 64'd0);
        step(0, 32'h0, 32'h0, 1, 0);
        cv = ctrl_o;
        chk("addi_valid", {63'd0, valid_o}, 64'd1);
        chk("addi_func1", {60'd0, cv.alu_func1}, {60'd0, ALU_ADD});
        chk("addi_sel2", {62'd0, cv.ex_sel2}, {62'd0, EX_IMM_PC});
        chk("addi_rf_we_n", {63'd0, cv.rf_we_n}, 64'd0);
        chk("addi_illegal", {63'd0, illegal_o}, 64'd0);
        step(0, 32'h0, 32'h0, 1, 0);

        // ---------------- backpressure, full, wrap ----------------
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1, 32'h0000_0013 | (32'(i) << 20), 32'h200 + 32'(i * 4), 0, 0);
            if (i == DEPTH) chk("full_ready", {63'd0, ready_o}, 64'd0);
        end
        for (int i = 0; i < 8; i++) step(0, 32'h0, 32'h0, 1, 0);

        // ---------------- flush with a concurrent push ----------------
        for (int i = 0; i < 3; i++) step(1, 32'h0010_0113, 32'h300 + 32'(i * 4), 0, 0);
        step(1, 32'h0020_0193, 32'h3F0, 0, 1);
        chk("flush_valid", {63'd0, valid_o}, 64'd0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("flush_drop", {63'd0, valid_o}, 64'd0);

        // ---------------- ebreak trap-hold ----------------
        step(1, 32'h0010_0073, 32'h400, 1, 0);
        step(1, 32'h0050_0093, 32'h404, 1, 0);
        chk("ebreak_o", {63'd0, ebreak_o}, 64'd1);
        for (int i = 0; i < 5; i++) step(0, 32'h0, 32'h0, 1, 0);
        chk("trap_hold", {63'd0, valid_o}, 64'd0);
        step(0, 32'h0, 32'h0, 1, 1);
        step(0, 32'h0, 32'h0, 1, 0);

        // ---------------- MUL ----------------
        step(1, 32'h0220_8033, 32'h500, 1, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        cv = ctrl_o;
        chk("mul_illegal", {63'd0, illegal_o}, {63'd0, !M_EN});
        chk("mul_muldiv", {63'd0, cv.muldiv}, {63'd0, M_EN});
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 1);

        // ---------------- unknown opcode ----------------
        step(1, 32'h0000_200F, 32'h600, 1, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        cv = ctrl_o;
        chk("unk_illegal", {63'd0, illegal_o}, 64'd1);
        chk("unk_we_n", {61'd0, cv.rf_we_n, cv.mem_we_n, cv.csr_we_n}, 64'd7);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 1);

        // ---------------- randomized traffic ----------------
        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            fl = ($urandom_range(0, 19) == 0) || (m_halt && ($urandom_range(0, 3) == 0));
            step($urandom_range(0, 2) != 0, rand_instr(), pc, $urandom_range(0, 3) != 0, fl);
            pc = pc + 32'd4;
        end

        // ---------------- asynchronous reset mid-operation ----------------
        for (int i = 0; i < 3; i++) step(1, 32'h0050_0093, 32'h2000 + 32'(i * 4), 0, 0);
        valid_i = 0; ready_i = 0; flush_i = 0;
        #2 reset_i = 1'b1;
        #1;
        chk("areset_valid", {63'd0, valid_o}, 64'd0);
        chk("areset_ready", {63'd0, ready_o}, 64'd1);
        chk("areset_ctrl", 64'(ctrl_o), 64'(CTRL_NOP));
        mq.delete(); exp_q.delete(); m_out = 0; m_halt = 0; m_ready = 1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        for (int i = 0; i < 6; i++) step(1, rand_instr(), 32'h3000 + 32'(i * 4), 1, 0);

        // ---------------- drain ----------------
        for (int i = 0; i < 12; i++) step(0, 32'h0, 32'h0, 1, 0);
        if (!m_halt) chk("drain_empty", 64'(exp_q.size()), 64'd0);
        step(0, 32'h0, 32'h0, 1, 1);
        step(0, 32'h0, 32'h0, 1, 0);
        chk("final_idle", {63'd0, valid_o}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
